// File: rtl/minibus_ram_slave_if.sv
// Minibus request/response types and the slave-side bus interface.
// The request is sampled by the slave; the response is fully registered inside it.
package minibus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [1:0]  width;
  } minibus_req_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        error;
  } minibus_res_t;

endpackage

interface minibus_slave_if;
  import minibus_pkg::*;

  minibus_req_t req;
  minibus_res_t res;

  modport slave  (input req, output res);
  modport master (output req, input res);
endinterface

// File: rtl/minibus_ram_slave.sv
// Word-organised RAM slave on the minibus with a fixed wait-state count per access.
// Faulted accesses complete with error=1 and never touch storage.
module minibus_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input logic            CLK,
  input logic            nRST,
  minibus_slave_if.slave bus
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [1:0]     lane_q, lane_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [1:0]     width_q, width_d;
  logic           wr_q, wr_d;
  logic           fault_q, fault_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [31:0]    rdata_q, rdata_d;

  logic [32:0]    req_off_s;
  logic [31:0]    rd_word_s;
  logic [31:0]    wr_mask_s;
  logic [31:0]    wr_val_s;
  logic           mem_we_s;

  logic [31:0]    mem [DEPTH_WORDS];

  function automatic logic access_fault(input logic [1:0] width, input logic [1:0] lane,
                                        input logic [32:0] off);
    logic range_bad;
    logic res;
    range_bad = (off >= LIMIT);
    case (width)
      2'b00:   res = range_bad;
      2'b01:   res = range_bad | lane[0];
      2'b10:   res = range_bad | (lane != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] width,
                                               input logic [1:0] lane);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {lane, 3'b000};
    case (width)
      2'b00:   res = {24'h000000, shifted[7:0]};
      2'b01:   res = {16'h0000, shifted[15:0]};
      2'b10:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Byte-lane write mask and lane-replicated store data for the latched access.
  always_comb begin
    wr_mask_s = 32'h0000_0000;
    wr_val_s  = 32'h0000_0000;
    case (width_q)
      2'b00: begin
        wr_mask_s = 32'h0000_00FF << {lane_q, 3'b000};
        wr_val_s  = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_mask_s = 32'h0000_FFFF << {lane_q[1], 4'b0000};
        wr_val_s  = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        wr_mask_s = 32'hFFFF_FFFF;
        wr_val_s  = wdata_q;
      end
      default: begin
        wr_mask_s = 32'h0000_0000;
        wr_val_s  = 32'h0000_0000;
      end
    endcase
  end

  assign req_off_s = {1'b0, bus.req.addr} - {1'b0, BASE_ADDR};
  assign rd_word_s = mem[idx_q];

  // Access FSM: next state, latched request fields and registered response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    width_d  = width_q;
    wr_d     = wr_q;
    fault_d  = fault_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = 32'h0000_0000;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req.wen || bus.req.ren) begin
          idx_d   = req_off_s[AW+1:2];
          lane_d  = bus.req.addr[1:0];
          wdata_d = bus.req.wdata;
          width_d = bus.req.width;
          wr_d    = bus.req.wen;
          fault_d = access_fault(bus.req.width, bus.req.addr[1:0], req_off_s);
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (fault_q) begin
            err_d = 1'b1;
          end else if (wr_q) begin
            mem_we_s = 1'b1;
          end else begin
            rdata_d = load_extract(rd_word_s, width_q, lane_q);
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wdata_q <= 32'h0000_0000;
      width_q <= 2'b00;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage keeps its contents through reset; a reset in WAIT drops the pending write.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem[idx_q] <= (rd_word_s & ~wr_mask_s) | (wr_val_s & wr_mask_s);
    end
  end

  assign bus.res.ack   = ack_q;
  assign bus.res.error = err_q;
  assign bus.res.rdata = rdata_q;

endmodule

// File: tb/tb_minibus_ram_slave.sv
// Scoreboard bench: LATENCY=1 instance for function, faults and reset abandonment;
// LATENCY=3 instance for held-request throughput.
module tb_minibus_ram_slave;
  import minibus_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  minibus_slave_if bus1 ();
  minibus_slave_if bus3 ();

  minibus_ram_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_dut1 (
    .CLK(clk), .nRST(nrst), .bus(bus1)
  );
  minibus_ram_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(3)) u_dut3 (
    .CLK(clk), .nRST(nrst), .bus(bus3)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   cyc = 0;
  bit   hold3 = 1'b0;
  int   last_ack3 = -1;
  logic prev_ack3 = 1'b0;
  int   ack3_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the LATENCY=1 instance: pop and compare on every ack.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.res.ack) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack actual ack=1 err=%0b rdata=%h required no ack",
                 bus1.res.error, bus1.res.rdata);
      end else begin
        e = sb_q.pop_front();
        if (bus1.res.error !== e.err || bus1.res.rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL %s actual err=%0b rdata=%h required err=%0b rdata=%h",
                   e.name, bus1.res.error, bus1.res.rdata, e.err, e.rdata);
        end
      end
    end else if (bus1.res.error !== 1'b0 || bus1.res.rdata !== 32'h0000_0000) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_outputs actual err=%0b rdata=%h required err=0 rdata=00000000",
               bus1.res.error, bus1.res.rdata);
    end
  end

  // Monitor for the LATENCY=3 instance: ack period and single-cycle width.
  always @(negedge clk) begin : mon3
    if (hold3 && bus3.res.ack) begin
      ack3_cnt++;
      if (last_ack3 >= 0) begin
        n_tests++;
        if (cyc - last_ack3 != 5) begin
          n_fail++;
          $display("FAIL ack_period actual %0d required 5", cyc - last_ack3);
        end
      end
      n_tests++;
      if (bus3.res.error !== 1'b0 || bus3.res.rdata !== 32'h0000_0000) begin
        n_fail++;
        $display("FAIL held_write_resp actual err=%0b rdata=%h required err=0 rdata=00000000",
                 bus3.res.error, bus3.res.rdata);
      end
      last_ack3 = cyc;
    end
    if (bus3.res.ack && prev_ack3) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack3_consecutive actual ack high twice required one-cycle pulse");
    end
    prev_ack3 = bus3.res.ack;
  end

  task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic wen, input logic ren, input logic [1:0] width,
                       input logic exp_err, input logic [31:0] exp_rdata);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    bus1.req.addr  = addr;
    bus1.req.wdata = wdata;
    bus1.req.wen   = wen;
    bus1.req.ren   = ren;
    bus1.req.width = width;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    e.name  = name;
    sb_q.push_back(e);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus1.req.wen = 1'b0;
        bus1.req.ren = 1'b0;
      end
      if (bus1.res.ack) got = 1'b1;
    end
    n_tests++;
    if (!got || n != 2) begin
      n_fail++;
      $display("FAIL %s_latency actual %0d cycles (ack seen=%0b) required 2", name, n, got);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus1.res.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ack_width actual ack=%0b required 0", name, bus1.res.ack);
    end
  endtask

  initial begin
    bus1.req = '0;
    bus3.req = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus1.res.ack !== 1'b0 || bus1.res.error !== 1'b0 || bus1.res.rdata !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL reset_state actual ack=%0b err=%0b rdata=%h required 0/0/00000000",
               bus1.res.ack, bus1.res.error, bus1.res.rdata);
    end
    @(negedge clk);
    nrst = 1'b1;

    issue("wr_word_10",  32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    issue("rd_word_10",  32'h10, 32'h0,        1'b0, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF);
    issue("clr_word_10", 32'h10, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    issue("wr_byte_11",  32'h11, 32'hFFFFFFAA, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    issue("rd_word_10b", 32'h10, 32'h0,        1'b0, 1'b1, 2'b10, 1'b0, 32'h0000AA00);
    issue("rd_half_12",  32'h12, 32'h0,        1'b0, 1'b1, 2'b01, 1'b0, 32'h00000000);
    issue("rd_byte_11",  32'h11, 32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 32'h000000AA);
    issue("wr_word_14",  32'h14, 32'hFFFFFFFF, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    issue("wr_half_16",  32'h16, 32'hABCD1234, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0);
    issue("rd_word_14",  32'h14, 32'h0,        1'b0, 1'b1, 2'b10, 1'b0, 32'h1234FFFF);
    issue("rd_byte_17",  32'h17, 32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 32'h00000012);
    issue("rd_half_14",  32'h14, 32'h0,        1'b0, 1'b1, 2'b01, 1'b0, 32'h0000FFFF);
    issue("wr_word_00",  32'h00, 32'h01020304, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);

    issue("flt_rd_half_13", 32'h13,   32'h0,        1'b0, 1'b1, 2'b01, 1'b1, 32'h0);
    issue("flt_rd_word_06", 32'h06,   32'h0,        1'b0, 1'b1, 2'b10, 1'b1, 32'h0);
    issue("flt_rd_w11",     32'h10,   32'h0,        1'b0, 1'b1, 2'b11, 1'b1, 32'h0);
    issue("flt_rd_range",   32'h1000, 32'h0,        1'b0, 1'b1, 2'b10, 1'b1, 32'h0);
    issue("flt_wr_word_12", 32'h12,   32'h55555555, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0);
    issue("flt_wr_w11",     32'h10,   32'h66666666, 1'b1, 1'b0, 2'b11, 1'b1, 32'h0);
    issue("flt_wr_half_13", 32'h13,   32'h77777777, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0);
    issue("flt_wr_range",   32'h1000, 32'h000000EE, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0);
    issue("post_flt_rd_10", 32'h10,   32'h0,        1'b0, 1'b1, 2'b10, 1'b0, 32'h0000AA00);
    issue("post_flt_rd_00", 32'h00,   32'h0,        1'b0, 1'b1, 2'b10, 1'b0, 32'h01020304);

    issue("wr_rd_both_20", 32'h20, 32'h12345678, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0);
    issue("rd_word_20",    32'h20, 32'h0,        1'b0, 1'b1, 2'b10, 1'b0, 32'h12345678);

    // Write abandoned by a reset pulse while in WAIT.
    issue("wr_word_30", 32'h30, 32'h11111111, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    bus1.req.addr  = 32'h30;
    bus1.req.wdata = 32'h22222222;
    bus1.req.width = 2'b10;
    bus1.req.wen   = 1'b1;
    @(posedge clk);
    #1;
    bus1.req.wen = 1'b0;
    nrst = 1'b0;
    #2;
    n_tests++;
    if (bus1.res.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_wait_ack actual ack=%0b required 0", bus1.res.ack);
    end
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (bus1.res.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after_release_ack actual ack=%0b required 0", bus1.res.ack);
    end
    issue("rd_after_rst_30", 32'h30, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h11111111);

    // Held write on the LATENCY=3 instance.
    @(negedge clk);
    bus3.req.addr  = 32'h40;
    bus3.req.wdata = 32'hCAFEF00D;
    bus3.req.width = 2'b10;
    bus3.req.wen   = 1'b1;
    hold3 = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);
    hold3 = 1'b0;
    bus3.req.wen = 1'b0;
    n_tests++;
    if (ack3_cnt != 6) begin
      n_fail++;
      $display("FAIL ack3_count actual %0d required 6", ack3_cnt);
    end

    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual %0d pending required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/minibus_ram_slave.md
MINIBUS_RAM_SLAVE -- requirements
Module: minibus_ram_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit storage words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0.
REQ-003 Parameter LATENCY, default 1, legal range 1..15, SHALL set the number of WAIT cycles per access.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 Bus port minibus_slave_if.slave carries the fields in REQ-007..REQ-014.
REQ-007 req.addr  input  32  byte address.
REQ-008 req.wdata  input  32  store data, right-aligned.
REQ-009 req.wen  input  1  write request.
REQ-010 req.ren  input  1  read request.
REQ-011 req.width  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-012 res.ack  output  1  one-cycle completion pulse.
REQ-013 res.rdata  output  32  load data, right-aligned and zero-extended.
REQ-014 res.error  output  1  access faulted; valid only with ack.

Function
REQ-015 States SHALL be IDLE, WAIT and ACK.
REQ-016 IDLE SHALL sample the request when wen or ren is high: latch addr, wdata, width, op and fault flag; load cnt=LATENCY-1; go to WAIT.
REQ-017 When wen and ren are both high, the access SHALL be a write.
REQ-018 WAIT with cnt!=0 SHALL decrement cnt; WAIT with cnt==0 SHALL perform the access and go to ACK.
REQ-019 ACK SHALL drive ack=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 ack SHALL rise exactly LATENCY+1 cycles after the cycle in which the request was first sampled.
REQ-021 Request inputs in WAIT and ACK SHALL be ignored; a request held in the cycle after ACK SHALL be sampled as a new access, giving back-to-back throughput of one access per LATENCY+2 cycles.
REQ-022 The fault flag SHALL be set for any of:
- width==11;
- width==01 with addr[0]==1;
- width==10 with addr[1:0]!=0;
- (addr-BASE_ADDR) >= DEPTH_WORDS*4, computed unsigned in 33 bits so that addr<BASE_ADDR faults.
REQ-023 A faulted access SHALL NOT modify storage; its ACK cycle SHALL drive error=1 and rdata=0.
REQ-024 Word index SHALL be (addr-BASE_ADDR)>>2; byte lane SHALL be addr[1:0].
REQ-025 Writes SHALL update only the addressed lanes:
- byte: lane addr[1:0] <- wdata[7:0];
- half: lanes addr[1]*2..+1 <- wdata[15:0];
- word: all lanes <- wdata.
REQ-026 Reads SHALL capture the addressed byte, half or word into a register, shifted to bit 0 and zero-extended; sign extension is the datapath's job.
REQ-027 Write ACK SHALL drive rdata=0.
REQ-028 Outside ACK, outputs SHALL be ack=0, error=0, rdata=0.
REQ-029 ack, error and rdata SHALL be registered, with no combinational path from req to res.

Reset
REQ-030 On nRST low, the state SHALL become IDLE, cnt 0, and ack/error/rdata 0, asynchronously.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 Reset asserted in WAIT or ACK SHALL abandon the access: no write if reset precedes the WAIT-exit edge, and no ack after reset releases.
REQ-033 The first request SHALL be sampled in the first IDLE cycle after nRST deasserts.

Verification
REQ-034 LATENCY=1: word write addr 0x10 data 0xDEADBEEF, then word read 0x10 -> ack 2 cycles after each request; read rdata=0xDEADBEEF, error=0.
REQ-035 Byte write 0xAA to 0x11 over word 0x00000000, then word read 0x10 -> rdata=0x0000AA00; half read 0x12 -> 0x00000000.
REQ-036 Half read addr 0x13, word read addr 0x06, width=11, and addr=DEPTH_WORDS*4 -> each gives ack=1, error=1, rdata=0, and storage is unchanged.
REQ-037 wen=ren=1 at addr 0x20 with wdata 0x12345678 -> treated as write; subsequent read returns 0x12345678.
REQ-038 LATENCY=3 with a request held continuously -> ack pulses of one cycle exactly every 5 cycles; ack is never high on consecutive cycles.
REQ-039 Write issued, nRST pulsed low during WAIT -> ack stays 0, state is IDLE, and a later read of that address returns the old contents.
